// File: rtl/imem_line_fill.sv
// Line-fill engine: turns a held I-cache line-read miss into one aligned bus burst
// and returns the assembled line with a single-cycle valid pulse.
module imem_line_fill #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       req_addr,
  input  logic              req_rd,
  output logic [LINE_W-1:0] line_data,
  output logic              line_dv,
  output logic [63:0]       m_addr,
  output logic              m_req,
  input  logic              m_gnt,
  input  logic [BUS_W-1:0]  m_rdata,
  input  logic              m_rvalid
);

  localparam int unsigned BEATS = LINE_W / BUS_W;
  localparam int unsigned OFFS  = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned TAG_W = 64 - OFFS;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BEAT,
    CHK
  } state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  a_lat_q, a_lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [63:0]       m_addr_q, m_addr_d;
  logic              m_req_q, m_req_d;
  logic              line_dv_q, line_dv_d;
  logic [TAG_W-1:0]  tag;
  logic              unused_offs;

  assign tag         = req_addr[63:OFFS];
  assign unused_offs = ^req_addr[OFFS-1:0];

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_lat_q   <= '0;
      cnt_q     <= '0;
      line_q    <= '0;
      m_addr_q  <= '0;
      m_req_q   <= 1'b0;
      line_dv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_lat_q   <= a_lat_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      m_addr_q  <= m_addr_d;
      m_req_q   <= m_req_d;
      line_dv_q <= line_dv_d;
    end
  end

  // Next-state and next-output logic; beats outside BEAT are ignored
  always_comb begin
    state_d   = state_q;
    a_lat_d   = a_lat_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    m_addr_d  = m_addr_q;
    m_req_d   = m_req_q;
    line_dv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_rd) begin
          a_lat_d  = tag;
          m_addr_d = {tag, {OFFS{1'b0}}};
          m_req_d  = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (m_gnt) begin
          m_req_d = 1'b0;
          cnt_d   = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (m_rvalid) begin
          line_d[32'(cnt_q) * BUS_W +: BUS_W] = m_rdata;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = CHK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHK: begin
        // Deliver only if the cache still wants this exact line
        line_dv_d = req_rd && (tag == a_lat_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_data = line_q;
  assign line_dv   = line_dv_q;
  assign m_addr    = m_addr_q;
  assign m_req     = m_req_q;

endmodule

// File: tb/tb_imem_line_fill.sv
// Randomized bench for imem_line_fill: a cache-side driver plus bus responder,
// checked against a transaction-level model of the expected line, address and pulse.
module tb_imem_line_fill;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BUS_W  = 64;
  localparam int unsigned BEATS  = LINE_W / BUS_W;

  logic              clk;
  logic              rst_n;
  logic [63:0]       req_addr;
  logic              req_rd;
  logic [LINE_W-1:0] line_data;
  logic              line_dv;
  logic [63:0]       m_addr;
  logic              m_req;
  logic              m_gnt;
  logic [BUS_W-1:0]  m_rdata;
  logic              m_rvalid;

  imem_line_fill #(.LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req_addr),
    .req_rd    (req_rd),
    .line_data (line_data),
    .line_dv   (line_dv),
    .m_addr    (m_addr),
    .m_req     (m_req),
    .m_gnt     (m_gnt),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fails  = 0;
  int                cyc      = 0;
  int                dv_cnt   = 0;
  int                dv_cyc   = 0;
  logic              prev_dv  = 1'b0;
  logic              chain_en = 1'b0;
  logic [63:0]       chain_addr = '0;
  logic              b2b_chk  = 1'b0;
  logic [LINE_W-1:0] line_model = '0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; models the cache reacting to line_dv (drop or move to the next line)
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (line_dv) begin
      check("dv_single", LINE_W'(prev_dv), LINE_W'(0));
      dv_cnt++;
      dv_cyc = cyc;
      if (chain_en) begin
        req_addr = chain_addr;
        chain_en = 1'b0;
      end else begin
        req_rd = 1'b0;
      end
    end
    prev_dv = line_dv;
  endtask

  // mode: 0 normal, 1 flush after alt_beat, 2 redirect after alt_beat, 3 reset at alt_beat
  task automatic run_fill(input logic [63:0] addr, input int gw, input int max_gap,
                          input int mode, input int alt_beat, input logic fixed_pat,
                          input logic [63:0] new_addr);
    logic [BUS_W-1:0]  d [BEATS];
    logic [LINE_W-1:0] exp_line;
    logic [63:0]       exp_addr;
    logic              exp_dv;
    int                c0, dv0, gaps, ng;

    exp_addr = addr & ~64'(LINE_W / 8 - 1);
    exp_line = '0;
    for (int k = 0; k < BEATS; k++) begin
      d[k] = fixed_pat ? {8{8'((k + 1) * 17)}} : {$urandom, $urandom};
      exp_line = {d[k], exp_line[LINE_W-1:BUS_W]};
    end
    exp_dv = (mode == 0);
    c0 = cyc;
    dv0 = dv_cnt;
    gaps = 0;

    req_addr = addr;
    req_rd = 1'b1;
    tick();
    check("m_req_set", LINE_W'(m_req), LINE_W'(1));
    check("m_addr", LINE_W'(m_addr), LINE_W'(exp_addr));
    if (b2b_chk) begin
      check("b2b_gap", LINE_W'(cyc - dv_cyc), LINE_W'(1));
      b2b_chk = 1'b0;
    end
    repeat (gw) begin
      tick();
      check("m_req_hold", LINE_W'(m_req), LINE_W'(1));
      check("m_addr_hold", LINE_W'(m_addr), LINE_W'(exp_addr));
    end
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    check("m_req_clr", LINE_W'(m_req), LINE_W'(0));

    for (int k = 0; k < BEATS; k++) begin
      ng = int'($urandom_range(max_gap, 0));
      repeat (ng) tick();
      gaps += ng;
      m_rvalid = 1'b1;
      m_rdata  = d[k];
      if (mode == 3 && k == alt_beat) begin
        rst_n  = 1'b0;
        req_rd = 1'b0;
      end
      tick();
      m_rvalid = 1'b0;
      if (mode == 3 && k == alt_beat) begin
        check("rst_m_req", LINE_W'(m_req), LINE_W'(0));
        check("rst_m_addr", LINE_W'(m_addr), LINE_W'(0));
        check("rst_line", line_data, LINE_W'(0));
        rst_n = 1'b1;
      end
      if (mode == 1 && k == alt_beat) req_rd = 1'b0;
      if (mode == 2 && k == alt_beat) req_addr = new_addr;
    end

    tick();
    check("line_dv", LINE_W'(line_dv), LINE_W'(exp_dv));
    check("dv_count", LINE_W'(dv_cnt - dv0), LINE_W'(exp_dv));
    check("m_req_idle", LINE_W'(m_req), LINE_W'(0));
    if (mode == 3) begin
      line_model = '0;
    end else begin
      line_model = exp_line;
    end
    check("line_data", line_data, line_model);
    if (exp_dv)
      check("latency", LINE_W'(cyc - c0), LINE_W'(7 + gw + gaps));
  endtask

  initial begin
    rst_n    = 1'b0;
    req_addr = '0;
    req_rd   = 1'b0;
    m_gnt    = 1'b0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    tick();
    tick();
    check("reset_m_req", LINE_W'(m_req), LINE_W'(0));
    check("reset_line_dv", LINE_W'(line_dv), LINE_W'(0));
    check("reset_line", line_data, LINE_W'(0));
    check("reset_m_addr", LINE_W'(m_addr), LINE_W'(0));
    rst_n = 1'b1;
    tick();

    run_fill(64'h8000_0024, 0, 0, 0, -1, 1'b1, '0);
    run_fill(64'h8000_0024, 5, 3, 0, -1, 1'b1, '0);

    run_fill(64'h8000_0000, 1, 2, 1, 1, 1'b0, '0);
    run_fill(64'h8000_0040, 0, 1, 0, -1, 1'b0, '0);

    run_fill(64'h8000_1000, 0, 1, 2, 1, 1'b0, 64'h8000_2008);
    run_fill(64'h8000_2008, 2, 1, 0, -1, 1'b0, '0);

    chain_en   = 1'b1;
    chain_addr = 64'h8000_0040;
    run_fill(64'h8000_003E, 0, 0, 0, -1, 1'b0, '0);
    b2b_chk = 1'b1;
    run_fill(64'h8000_0040, 1, 1, 0, -1, 1'b0, '0);

    // Stray beats while idle must not touch the line
    req_rd = 1'b0;
    repeat (2) begin
      m_rvalid = 1'b1;
      m_rdata  = {$urandom, $urandom};
      tick();
    end
    m_rvalid = 1'b0;
    check("stray_line", line_data, line_model);
    check("stray_m_req", LINE_W'(m_req), LINE_W'(0));
    check("stray_dv", LINE_W'(line_dv), LINE_W'(0));

    run_fill(64'h8000_0300, 1, 1, 3, 2, 1'b0, '0);
    run_fill(64'h8000_0360, 0, 0, 0, -1, 1'b0, '0);

    for (int i = 0; i < 8; i++) begin
      run_fill({$urandom, $urandom}, int'($urandom_range(4, 0)), 3, 0, -1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
